// File: rtl/makehint_ctrl.sv
// MakeHint controller: per-lane hint generation, beat/poly sequencing and OMEGA limit tracking.
// Optional build macro MAKEHINT_OMEGA_ABORT_EN ends a run early once the hint count exceeds OMEGA.
module makehint_ctrl #(
  parameter int K        = 8,
  parameter int OMEGA    = 75,
  parameter int REG_SIZE = 23,
  localparam int LANES   = 4,
  localparam int PIW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      zeroize,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*REG_SIZE-1:0] r_in,
  input  logic [LANES-1:0]          z_neq_z_in,
  output logic                      hint_valid,
  output logic [LANES-1:0]          hint_vec,
  output logic [7:0]                coeff_idx,
  output logic [PIW-1:0]            poly_idx,
  output logic                      poly_done,
  output logic [7:0]                hint_cnt,
  output logic                      done,
  output logic                      invalid,
  output logic                      busy
);

  localparam int Q      = 8380417;
  localparam int GAMMA2 = (Q - 1) / 32;

  localparam logic [REG_SIZE-1:0] GAMMA2_R = REG_SIZE'(GAMMA2);
  localparam logic [REG_SIZE-1:0] QMG_R    = REG_SIZE'(Q - GAMMA2);
  localparam logic [8:0]          OMEGA_R  = 9'(OMEGA);
  localparam logic [PIW-1:0]      LAST_POLY = PIW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]       beat_q;
  logic [PIW-1:0]   poly_q;
  logic [LANES-1:0] lane_hint;
  logic [2:0]       pop;
  logic [8:0]       cnt_sum;
  logic [7:0]       cnt_next;
  logic             over_next;
  logic             accept;
  logic             last_beat;
  logic             wrap_beat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [REG_SIZE-1:0] r_lane;
    assign r_lane       = r_in[g*REG_SIZE +: REG_SIZE];
    assign lane_hint[g] = ~((r_lane <= GAMMA2_R) | (r_lane >= QMG_R))
                        | ((r_lane == QMG_R) & z_neq_z_in[g]);
  end

  always_comb begin
    in_ready  = (state_q == RUN) & ~zeroize;
    accept    = in_ready & in_valid;
    wrap_beat = (beat_q == 6'd63);
    last_beat = wrap_beat & (poly_q == LAST_POLY);

    pop = 3'(lane_hint[0]) + 3'(lane_hint[1]) + 3'(lane_hint[2]) + 3'(lane_hint[3]);

    // Saturating accumulate; the limit flag is sticky for the rest of the run.
    cnt_sum   = {1'b0, hint_cnt} + 9'(pop);
    cnt_next  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    over_next = invalid | ({1'b0, cnt_next} > OMEGA_R);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (accept) begin
          if (last_beat) begin
            state_d = FLUSH;
          end
`ifdef MAKEHINT_OMEGA_ABORT_EN
          else if (over_next) begin
            state_d = FLUSH;
          end
`endif
        end
      end
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      poly_q     <= '0;
      hint_valid <= 1'b0;
      hint_vec   <= '0;
      coeff_idx  <= '0;
      poly_idx   <= '0;
      poly_done  <= 1'b0;
      hint_cnt   <= '0;
      invalid    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hint_valid <= accept;
      poly_done  <= accept & wrap_beat;
      if (accept) begin
        hint_vec  <= lane_hint;
        coeff_idx <= {beat_q, 2'b00};
        poly_idx  <= poly_q;
        hint_cnt  <= cnt_next;
        invalid   <= over_next;
        beat_q    <= beat_q + 6'd1;
        if (wrap_beat) begin
          poly_q <= (poly_q == LAST_POLY) ? '0 : poly_q + PIW'(1);
        end
      end
      if ((state_q == IDLE) && start) begin
        beat_q   <= '0;
        poly_q   <= '0;
        hint_cnt <= '0;
        invalid  <= 1'b0;
      end
    end
  end

  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule
